lupdate_param: RTL and testbench

Parametrised beacon-update endpoint on the switch's local-management path, placed between the LCM report path and the embedded switch. It forwards ordinary 134-bit packets unchanged and drops foreign copies of locally sourced packets. Beacon update messages addressed to this node are consumed: they load the control registers and a MAC/port table of `NUM_ENTRY` entries. Updates are staged in shadow registers and committed atomically only when the message is complete and correctly framed.

---
 rtl/lupdate_param.sv | 227 ++++++++++++++++++++++
 tb/tb_lupdate_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lupdate_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : lupdate_param
//  Purpose  : Beacon-update endpoint. Forwards ordinary packets, drops foreign
//             copies of locally sourced packets, and commits beacon updates
//             atomically from shadow registers.
//  Option   : LUPDATE_STAT_EN adds the upd_err_cnt / upd_ok_cnt counters.
//  Revision : 1.0 - initial release
// ============================================================================
module lupdate_param #(
    parameter int         NUM_ENTRY       = 12,
    parameter logic [3:0] MSG_TYPE_UPDATE = 4'hf
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [133:0]              in_lu_data,
    input  logic                      in_lu_data_wr,
    input  logic                      in_lu_data_valid,
    input  logic                      in_lu_data_valid_wr,
    input  logic [47:0]               in_local_mac_id,
    output logic [133:0]              out_lu_data,
    output logic                      out_lu_data_wr,
    output logic                      out_lu_data_valid,
    output logic                      out_lu_data_valid_wr,
    output logic                      beacon_update_master,
    output logic [31:0]               time_slot_period,
    output logic                      direction,
    output logic                      reg_tap,
    output logic [15:0]               token_bucket_para,
    output logic [15:0]               token_bucket_depth,
    output logic [47:0]               direct_mac_addr,
    output logic [48*NUM_ENTRY-1:0]   mac_table,
    output logic [16*NUM_ENTRY-1:0]   port_table
`ifdef LUPDATE_STAT_EN
    ,
    output logic [15:0]               upd_err_cnt,
    output logic [15:0]               upd_ok_cnt
`endif
);

    localparam int         c_PAIRS = NUM_ENTRY / 2;
    localparam logic [4:0] c_K_CFG = 5'd5;
    localparam logic [4:0] c_K_END = 5'(5 + c_PAIRS);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_TRAN  = 3'd1;
    localparam logic [2:0] c_DISC  = 3'd2;
    localparam logic [2:0] c_UPD   = 3'd3;
    localparam logic [2:0] c_FLUSH = 3'd4;

    logic [2:0]   r_state;
    logic [4:0]   r_k;
    logic [133:0] r_s1_data, r_s2_data;
    logic         r_s1_wr, r_s1_valid, r_s1_valid_wr;
    logic         r_s2_wr, r_s2_valid, r_s2_valid_wr;

    logic [31:0]             r_sh_period, w_sh_period;
    logic                    r_sh_dir, w_sh_dir;
    logic                    r_sh_tap, w_sh_tap;
    logic [15:0]             r_sh_para, w_sh_para;
    logic [15:0]             r_sh_depth, w_sh_depth;
    logic [47:0]             r_sh_dmac, w_sh_dmac;
    logic [48*NUM_ENTRY-1:0] r_sh_mac, w_sh_mac;
    logic [16*NUM_ENTRY-1:0] r_sh_port, w_sh_port;

    logic w_s2_head, w_s2_tail, w_in_tail;
    logic w_is_upd, w_is_disc, w_fwd, w_upd_word, w_at_end, w_commit;

    assign w_s2_head  = r_s2_wr && (r_s2_data[133:132] == 2'b01);
    assign w_s2_tail  = r_s2_wr && (r_s2_data[133:132] == 2'b10);
    assign w_in_tail  = in_lu_data_wr && (in_lu_data[133:132] == 2'b10);
    // While the head sits in s2, the input carries the addressing word (k=2)
    assign w_is_upd   = (in_lu_data[127:80] == in_local_mac_id) &&
                        (in_lu_data[11:8] == MSG_TYPE_UPDATE);
    assign w_is_disc  = !w_is_upd && (in_lu_data[79:32] == in_local_mac_id) &&
                        !r_s2_data[127];
    assign w_fwd      = (r_state == c_TRAN) ||
                        ((r_state == c_IDLE) && w_s2_head && !w_is_upd && !w_is_disc);
    assign w_upd_word = (r_state == c_UPD) && r_s2_wr;
    assign w_at_end   = (r_k == c_K_END);
    assign w_commit   = w_upd_word && w_s2_tail && w_at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data <= '0; r_s1_wr <= 1'b0; r_s1_valid <= 1'b0; r_s1_valid_wr <= 1'b0;
            r_s2_data <= '0; r_s2_wr <= 1'b0; r_s2_valid <= 1'b0; r_s2_valid_wr <= 1'b0;
            out_lu_data          <= '0;
            out_lu_data_wr       <= 1'b0;
            out_lu_data_valid    <= 1'b0;
            out_lu_data_valid_wr <= 1'b0;
        end else begin
            r_s1_data     <= in_lu_data;
            r_s1_wr       <= in_lu_data_wr;
            r_s1_valid    <= in_lu_data_valid;
            r_s1_valid_wr <= in_lu_data_valid_wr;
            r_s2_data     <= r_s1_data;
            r_s2_wr       <= r_s1_wr;
            r_s2_valid    <= r_s1_valid;
            r_s2_valid_wr <= r_s1_valid_wr;
            out_lu_data          <= w_fwd ? r_s2_data : '0;
            out_lu_data_wr       <= w_fwd && r_s2_wr;
            out_lu_data_valid    <= w_fwd && r_s2_valid;
            out_lu_data_valid_wr <= w_fwd && r_s2_valid_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_k     <= 5'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_s2_head) begin
                        r_k <= 5'd1;
                        if (w_is_upd)
                            r_state <= c_UPD;
                        else if (w_is_disc)
                            r_state <= w_in_tail ? c_IDLE : c_DISC;
                        else
                            r_state <= c_TRAN;
                    end
                end
                c_TRAN:  if (w_s2_tail) r_state <= c_IDLE;
                c_DISC:  if (w_in_tail) r_state <= c_IDLE;
                c_UPD: begin
                    if (r_s2_wr) begin
                        r_k <= r_k + 5'd1;
                        if (w_s2_tail)
                            r_state <= c_IDLE;
                        else if (w_at_end)
                            r_state <= c_FLUSH;
                    end
                end
                c_FLUSH: if (w_s2_tail) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Next shadow image; the tail word may carry the last table pair, so the
    // commit copies this merged value rather than the registered shadow.
    always_comb begin
        w_sh_period = r_sh_period;
        w_sh_dir    = r_sh_dir;
        w_sh_tap    = r_sh_tap;
        w_sh_para   = r_sh_para;
        w_sh_depth  = r_sh_depth;
        w_sh_dmac   = r_sh_dmac;
        w_sh_mac    = r_sh_mac;
        w_sh_port   = r_sh_port;
        if (w_upd_word) begin
            if (r_k == c_K_CFG) begin
                w_sh_dmac   = r_s2_data[127:80];
                w_sh_dir    = r_s2_data[72];
                w_sh_tap    = r_s2_data[64];
                w_sh_depth  = r_s2_data[63:48];
                w_sh_para   = r_s2_data[47:32];
                w_sh_period = r_s2_data[31:0];
            end
            for (int j = 0; j < c_PAIRS; j++) begin
                if (r_k == 5'(6 + j)) begin
                    w_sh_mac[96*j +: 48]      = r_s2_data[127:80];
                    w_sh_port[32*j +: 16]     = r_s2_data[79:64];
                    w_sh_mac[96*j+48 +: 48]   = r_s2_data[63:16];
                    w_sh_port[32*j+16 +: 16]  = r_s2_data[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_period <= '0; r_sh_dir <= 1'b0; r_sh_tap <= 1'b0;
            r_sh_para <= '0; r_sh_depth <= '0; r_sh_dmac <= '0;
            r_sh_mac <= '0; r_sh_port <= '0;
        end else begin
            r_sh_period <= w_sh_period; r_sh_dir <= w_sh_dir; r_sh_tap <= w_sh_tap;
            r_sh_para <= w_sh_para; r_sh_depth <= w_sh_depth; r_sh_dmac <= w_sh_dmac;
            r_sh_mac <= w_sh_mac; r_sh_port <= w_sh_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beacon_update_master <= 1'b0;
            time_slot_period     <= 32'd10;
            direction            <= 1'b0;
            reg_tap              <= 1'b0;
            token_bucket_para    <= 16'd100;
            token_bucket_depth   <= 16'd2048;
            direct_mac_addr      <= '0;
            mac_table            <= '0;
            port_table           <= '0;
        end else if (w_commit) begin
            beacon_update_master <= ~beacon_update_master;
            time_slot_period     <= w_sh_period;
            direction            <= w_sh_dir;
            reg_tap              <= w_sh_tap;
            token_bucket_para    <= w_sh_para;
            token_bucket_depth   <= w_sh_depth;
            direct_mac_addr      <= w_sh_dmac;
            mac_table            <= w_sh_mac;
            port_table           <= w_sh_port;
        end
    end

`ifdef LUPDATE_STAT_EN
    logic w_abort;
    assign w_abort = w_upd_word && (w_s2_tail != w_at_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_err_cnt <= '0;
            upd_ok_cnt  <= '0;
        end else begin
            if (w_abort && (upd_err_cnt != 16'hFFFF))
                upd_err_cnt <= upd_err_cnt + 16'd1;
            if (w_commit && (upd_ok_cnt != 16'hFFFF))
                upd_ok_cnt <= upd_ok_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lupdate_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lupdate_param
//  Purpose  : Directed scoreboard bench for lupdate_param (default 12 entries).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lupdate_param;

    localparam int          NUM_ENTRY = 12;
    localparam int          PAIRS     = NUM_ENTRY / 2;
    localparam logic [47:0] LOCAL_MAC = 48'hAABBCCDDEEFF;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [133:0]              in_lu_data = '0;
    logic                      in_lu_data_wr = 1'b0;
    logic                      in_lu_data_valid = 1'b0;
    logic                      in_lu_data_valid_wr = 1'b0;
    logic [47:0]               in_local_mac_id = LOCAL_MAC;
    logic [133:0]              out_lu_data;
    logic                      out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr;
    logic                      beacon_update_master;
    logic [31:0]               time_slot_period;
    logic                      direction, reg_tap;
    logic [15:0]               token_bucket_para, token_bucket_depth;
    logic [47:0]               direct_mac_addr;
    logic [48*NUM_ENTRY-1:0]   mac_table;
    logic [16*NUM_ENTRY-1:0]   port_table;
`ifdef LUPDATE_STAT_EN
    logic [15:0]               upd_err_cnt, upd_ok_cnt;
`endif

    lupdate_param #(.NUM_ENTRY(NUM_ENTRY), .MSG_TYPE_UPDATE(4'hf)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_lu_data(in_lu_data), .in_lu_data_wr(in_lu_data_wr),
        .in_lu_data_valid(in_lu_data_valid), .in_lu_data_valid_wr(in_lu_data_valid_wr),
        .in_local_mac_id(in_local_mac_id),
        .out_lu_data(out_lu_data), .out_lu_data_wr(out_lu_data_wr),
        .out_lu_data_valid(out_lu_data_valid), .out_lu_data_valid_wr(out_lu_data_valid_wr),
        .beacon_update_master(beacon_update_master),
        .time_slot_period(time_slot_period), .direction(direction), .reg_tap(reg_tap),
        .token_bucket_para(token_bucket_para), .token_bucket_depth(token_bucket_depth),
        .direct_mac_addr(direct_mac_addr), .mac_table(mac_table), .port_table(port_table)
`ifdef LUPDATE_STAT_EN
        , .upd_err_cnt(upd_err_cnt), .upd_ok_cnt(upd_ok_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           due;
        logic [133:0] d;
        logic         v;
        logic         vw;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [133:0] pkt[$];

    // Bench-side reference model of the register outputs
    logic [31:0]             exp_period;
    logic                    exp_dir, exp_tap, exp_toggle;
    logic [15:0]             exp_para, exp_depth, exp_err, exp_ok;
    logic [47:0]             exp_dmac;
    logic [48*NUM_ENTRY-1:0] exp_mac;
    logic [16*NUM_ENTRY-1:0] exp_port;

    // Contents of the next update message
    logic [31:0] upd_period;
    logic        upd_dir, upd_tap;
    logic [15:0] upd_para, upd_depth;
    logic [47:0] upd_dmac;
    logic [47:0] upd_mac [NUM_ENTRY];
    logic [15:0] upd_port[NUM_ENTRY];

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (out_lu_data_wr || out_lu_data_valid_wr)) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {out_lu_data_valid_wr, out_lu_data_wr, out_lu_data}, '0);
            end else begin
                mon_e = sb.pop_front();
                chk("fwd_cycle", mon_e.due == cyc ? 576'd1 : 576'd0, 576'd1);
                chk("fwd_data", out_lu_data, mon_e.d);
                chk("fwd_wr", out_lu_data_wr, 1'b1);
                chk("fwd_valid_wr", out_lu_data_valid_wr, mon_e.vw);
                chk("fwd_valid", out_lu_data_valid, mon_e.v);
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        exp_period = 32'd10; exp_para = 16'd100; exp_depth = 16'd2048;
        exp_dir = 1'b0; exp_tap = 1'b0; exp_dmac = '0; exp_toggle = 1'b0;
        exp_mac = '0; exp_port = '0; exp_err = '0; exp_ok = '0;
    endtask

    task automatic model_commit();
        exp_period = upd_period; exp_para = upd_para; exp_depth = upd_depth;
        exp_dir = upd_dir; exp_tap = upd_tap; exp_dmac = upd_dmac;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            exp_mac[48*i +: 48]  = upd_mac[i];
            exp_port[16*i +: 16] = upd_port[i];
        end
        exp_toggle = ~exp_toggle;
        exp_ok++;
    endtask

    task automatic rand_update();
        upd_period = $urandom(); upd_dir = 1'($urandom()); upd_tap = 1'($urandom());
        upd_para = 16'($urandom()); upd_depth = 16'($urandom());
        upd_dmac = 48'({$urandom(), $urandom()});
        for (int i = 0; i < NUM_ENTRY; i++) begin
            upd_mac[i]  = 48'({$urandom(), $urandom()});
            upd_port[i] = 16'($urandom());
        end
    endtask

    task automatic gen_plain(input logic h127, input logic [47:0] dst, input logic [47:0] src,
                             input logic [3:0] mtype, input int nwords);
        logic [133:0] w;
        pkt.delete();
        for (int k = 0; k < nwords; k++) begin
            w = {6'b0, rand128()};
            if (k == 0) begin w[133:132] = 2'b01; w[127] = h127; end
            if (k == 2) begin w[127:80] = dst; w[79:32] = src; w[11:8] = mtype; end
            if (k == nwords - 1) w[133:132] = 2'b10;
            pkt.push_back(w);
        end
    endtask

    task automatic gen_update(input logic [47:0] src, input int nwords);
        logic [133:0] w;
        pkt.delete();
        for (int k = 0; k < nwords; k++) begin
            w = {6'b0, rand128()};
            if (k == 0) begin w[133:132] = 2'b01; w[127] = 1'b0; end
            if (k == 2) begin w[127:80] = LOCAL_MAC; w[79:32] = src; w[11:8] = 4'hf; end
            if (k == 5) begin
                w[127:80] = upd_dmac; w[72] = upd_dir; w[64] = upd_tap;
                w[63:48] = upd_depth; w[47:32] = upd_para; w[31:0] = upd_period;
            end
            if (k >= 6 && k < 6 + PAIRS) begin
                w[127:80] = upd_mac[2*(k-6)];   w[79:64] = upd_port[2*(k-6)];
                w[63:16]  = upd_mac[2*(k-6)+1]; w[15:0]  = upd_port[2*(k-6)+1];
            end
            if (k == nwords - 1) w[133:132] = 2'b10;
            pkt.push_back(w);
        end
    endtask

    // Drive pkt[lo..hi]; gap idle cycles follow every word after k=2 except the tail
    task automatic send_range(input int lo, input int hi, input int gap, input bit fwd);
        bit last;
        for (int i = lo; i <= hi; i++) begin
            last = (i == pkt.size() - 1);
            in_lu_data = pkt[i]; in_lu_data_wr = 1'b1;
            in_lu_data_valid = last; in_lu_data_valid_wr = last;
            if (fwd) sb.push_back('{cyc + 3, pkt[i], last, last});
            @(posedge clk); #1;
            in_lu_data = '0; in_lu_data_wr = 1'b0;
            in_lu_data_valid = 1'b0; in_lu_data_valid_wr = 1'b0;
            if (!last && i >= 2)
                repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_pkt(input int gap, input bit fwd);
        send_range(0, pkt.size() - 1, gap, fwd);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_cfg(input string tag);
        @(negedge clk);
        chk({tag, ".period"}, time_slot_period, exp_period);
        chk({tag, ".para"}, token_bucket_para, exp_para);
        chk({tag, ".depth"}, token_bucket_depth, exp_depth);
        chk({tag, ".dir"}, direction, exp_dir);
        chk({tag, ".tap"}, reg_tap, exp_tap);
        chk({tag, ".dmac"}, direct_mac_addr, exp_dmac);
        chk({tag, ".mac_table"}, mac_table, exp_mac);
        chk({tag, ".port_table"}, port_table, exp_port);
        chk({tag, ".toggle"}, beacon_update_master, exp_toggle);
`ifdef LUPDATE_STAT_EN
        chk({tag, ".err_cnt"}, upd_err_cnt, exp_err);
        chk({tag, ".ok_cnt"}, upd_ok_cnt, exp_ok);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset.out_wr", {out_lu_data_valid_wr, out_lu_data_valid, out_lu_data_wr, out_lu_data}, '0);
        @(posedge clk); #1;
        chk_cfg("reset");

        // Ordinary packet is forwarded verbatim
        gen_plain(1'b0, 48'h112233445566, 48'h0102030405A0, 4'h0, 4);
        send_pkt(0, 1'b1);
        idle(5);

        // Local-sourced copy dropped, then back-to-back ordinary packet forwarded
        gen_plain(1'b0, 48'h665544332211, LOCAL_MAC, 4'h0, 5);
        send_pkt(0, 1'b0);
        gen_plain(1'b0, 48'h123456789ABC, 48'h0A0000000001, 4'h2, 3);
        send_pkt(0, 1'b1);
        // Internally generated (head[127]=1) local-sourced packet is forwarded
        gen_plain(1'b1, 48'h665544332211, LOCAL_MAC, 4'h0, 4);
        send_pkt(0, 1'b1);
        // Addressed here but not an update type: forwarded
        gen_plain(1'b0, LOCAL_MAC, 48'h0B0000000002, 4'h3, 4);
        send_pkt(0, 1'b1);
        idle(5);
        chk_cfg("after_fwd");

        // Full update; src = local checks update priority over drop
        rand_update();
        upd_period = 32'h40; upd_mac[0] = 48'h0A0B0C0D0E0F; upd_port[0] = 16'h0003;
        gen_update(LOCAL_MAC, 6 + PAIRS);
        send_pkt(0, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("commit_early.toggle", beacon_update_master, exp_toggle);
        chk("commit_early.period", time_slot_period, exp_period);
        model_commit();
        @(negedge clk);
        chk("commit_edge.toggle", beacon_update_master, exp_toggle);
        chk("commit_edge.period", time_slot_period, 32'h40);
        chk("commit_edge.mac0", mac_table[47:0], 48'h0A0B0C0D0E0F);
        chk("commit_edge.port0", port_table[15:0], 16'h0003);
        idle(3);
        chk_cfg("update1");

        // Truncated update: tail at k=8, nothing changes
        rand_update();
        gen_update(48'h0C0000000003, 9);
        send_pkt(0, 1'b0);
        exp_err++;
        idle(5);
        chk_cfg("truncated");

        // Gapped update
        rand_update();
        gen_update(48'h0C0000000004, 6 + PAIRS);
        send_pkt(2, 1'b0);
        model_commit();
        idle(5);
        chk_cfg("gapped");

        // Overlong update: aborted at k_end, flushed, next packet back-to-back
        rand_update();
        gen_update(48'h0C0000000005, 8 + PAIRS);
        send_pkt(0, 1'b0);
        exp_err++;
        gen_plain(1'b0, 48'h223344556677, 48'h0D0000000006, 4'hf, 5);
        send_pkt(0, 1'b1);
        idle(5);
        chk_cfg("overlong");

        // Reset during word 7 of an update
        rand_update();
        gen_update(48'h0C0000000007, 6 + PAIRS);
        send_range(0, 7, 0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_reset();
        chk_cfg("mid_reset");
        send_range(8, 5 + PAIRS, 0, 1'b0);
        idle(5);
        chk_cfg("post_reset_tail");
        rand_update();
        gen_update(48'h0C0000000008, 6 + PAIRS);
        send_pkt(0, 1'b0);
        model_commit();
        idle(5);
        chk_cfg("update_after_reset");
        chk("final.toggle", beacon_update_master, 1'b1);

        idle(4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
